afifo_rdrain_s_w: RTL and testbench

Read-side drain stage for the slave-to-wrapper asynchronous FIFO. It sits directly downstream of the FIFO in the read (wrapper) clock domain. It pops packed response words out of the FIFO, unpacks them into AXI R-channel fields, and presents them through a two-entry registered buffer, so that `rready` never combinationally reaches the FIFO's `rpop`. It also tracks beats per burst and flags bursts that run past the maximum length without `rlast`.

---
 rtl/afifo_rdrain_s_w_pkg.sv | 16 +
 rtl/afifo_rdrain_s_w_skid_buf2.sv | 32 +++
 rtl/afifo_rdrain_s_w.sv | 63 ++++++
 tb/tb_afifo_rdrain_s_w.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/afifo_rdrain_s_w_pkg.sv
// afifo_rdrain_s_w_pkg: shared widths, packed R-word layout and AXI response codes
package afifo_rdrain_s_w_pkg;
    localparam int S_W_ID_W     = 8;
    localparam int S_W_DATA_W   = 32;
    localparam int S_W_DATASIZE = S_W_ID_W + S_W_DATA_W + 3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    typedef struct packed {
        logic [S_W_ID_W-1:0]   rid;
        logic [S_W_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
    } r_word_t;
endpackage

// File: rtl/afifo_rdrain_s_w_skid_buf2.sv
// afifo_rdrain_s_w_skid_buf2: two-entry registered valid/ready buffer, in_ready derived from registers only
module afifo_rdrain_s_w_skid_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [1:0]   r_cnt;
    logic [W-1:0] r_out;
    logic [W-1:0] r_skid;
    logic         w_push;
    logic         w_hs;
    assign in_ready  = r_cnt != 2'd2;
    assign out_valid = r_cnt != 2'd0;
    assign out_data  = r_out;
    assign w_push    = in_valid && in_ready;
    assign w_hs      = out_valid && out_ready;
    // OUT reloads only when empty, when draining, or from SKID; otherwise it holds for AXI stability
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_hs};
        if (r_cnt == 2'd2 ? w_hs : w_push && (r_cnt == 2'd0 || w_hs))
            r_out <= r_cnt == 2'd2 ? r_skid : in_data;
        if (w_push && r_cnt == 2'd1 && !w_hs) r_skid <= in_data;
    end
endmodule

// File: rtl/afifo_rdrain_s_w.sv
// afifo_rdrain_s_w: drains the s->w async FIFO into a registered R channel, tracks burst length and overruns
module afifo_rdrain_s_w
    import afifo_rdrain_s_w_pkg::*;
#(
    parameter int ID_W      = S_W_ID_W,
    parameter int DATA_W    = S_W_DATA_W,
    parameter int MAX_BEATS = 256,
    parameter int FIFO_W    = ID_W + DATA_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FIFO_W-1:0] fifo_rdata,
    input  logic              fifo_rempty,
    output logic              fifo_rpop,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic              burst_done,
    output logic              overrun_err
);
    localparam int BC_W = $clog2(MAX_BEATS) + 1;
    logic              w_in_valid;
    logic              w_in_ready;
    logic              w_hs;
    logic [FIFO_W-1:0] w_out;
    logic [BC_W-1:0]   r_beat;
    logic              r_burst_done;
    logic              r_overrun;
    assign w_in_valid = !fifo_rempty && !rst;
    assign fifo_rpop  = w_in_valid && w_in_ready;
    afifo_rdrain_s_w_skid_buf2 #(.W(FIFO_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_data   (fifo_rdata),
        .out_valid (rvalid),
        .out_ready (rready),
        .out_data  (w_out)
    );
    assign {rid, rdata, rresp, rlast} = w_out;
    assign w_hs        = rvalid && rready;
    assign burst_done  = r_burst_done;
    assign overrun_err = r_overrun;
    // a non-last beat at MAX_BEATS-1 is one too many; the counter saturates there
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat       <= '0;
            r_burst_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_burst_done <= w_hs && rlast;
            if (w_hs) begin
                if (rlast) r_beat <= '0;
                else if (r_beat == BC_W'(MAX_BEATS - 1)) r_overrun <= 1'b1;
                else r_beat <= r_beat + BC_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_afifo_rdrain_s_w.sv
// tb_afifo_rdrain_s_w: queue-modelled FIFO feeding the drain stage, scoreboard of expected R beats
module tb_afifo_rdrain_s_w;
    import afifo_rdrain_s_w_pkg::*;
    localparam int MAXB = 256;
    logic                    clk = 1'b0;
    logic                    rst;
    logic [S_W_DATASIZE-1:0] fifo_rdata;
    logic                    fifo_rempty;
    logic                    fifo_rpop;
    logic [S_W_ID_W-1:0]     rid;
    logic [S_W_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;
    logic                    burst_done;
    logic                    overrun_err;
    r_word_t                 fq[$];
    r_word_t                 exp_q[$];
    int                      checks = 0;
    int                      failures = 0;
    int                      in_flight = 0;
    int                      exp_beat = 0;
    int                      bd_count = 0;
    logic                    exp_ov = 1'b0;
    logic                    exp_bd = 1'b0;
    logic                    prev_stall = 1'b0;
    logic                    armed = 1'b0;
    logic [S_W_DATASIZE-1:0] prev_out = '0;

    always #5 clk = ~clk;

    afifo_rdrain_s_w dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .fifo_rpop   (fifo_rpop),
        .rid         (rid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rlast       (rlast),
        .rvalid      (rvalid),
        .rready      (rready),
        .burst_done  (burst_done),
        .overrun_err (overrun_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] id, input logic [31:0] d, input logic [1:0] rs, input logic l);
        r_word_t w;
        w.rid = id;
        w.rdata = d;
        w.rresp = rs;
        w.rlast = l;
        fq.push_back(w);
        exp_q.push_back(w);
    endtask

    // one cycle: drive at negedge, check against the model, advance the model across the posedge
    task automatic step(input logic rdy);
        r_word_t w;
        logic    hs;
        logic    pop;
        rready = rdy;
        fifo_rempty = fq.size() == 0;
        fifo_rdata = fifo_rempty ? '0 : fq[0];
        #1;
        pop = !fifo_rempty && in_flight != 2 && !rst;
        chk("rpop", fifo_rpop, pop);
        if (armed) begin
            chk("rvalid", rvalid, in_flight != 0);
            chk("burst_done", burst_done, exp_bd);
            chk("overrun", overrun_err, exp_ov);
            if (burst_done) bd_count++;
        end
        if (prev_stall) chk("stable", {rid, rdata, rresp, rlast}, prev_out);
        hs = rvalid && rready && !rst && in_flight != 0;
        exp_bd = 1'b0;
        if (hs) begin
            w = exp_q.pop_front();
            chk("rid", rid, w.rid);
            chk("rdata", rdata, w.rdata);
            chk("rresp", rresp, w.rresp);
            chk("rlast", rlast, w.rlast);
            in_flight--;
            exp_bd = w.rlast;
            if (w.rlast) exp_beat = 0;
            else if (exp_beat == MAXB - 1) exp_ov = 1'b1;
            else exp_beat++;
        end
        if (pop) begin
            w = fq.pop_front();
            in_flight++;
        end
        if (rst) begin
            repeat (in_flight) w = exp_q.pop_front();
            in_flight = 0;
            exp_beat = 0;
            exp_ov = 1'b0;
            exp_bd = 1'b0;
        end
        prev_stall = rvalid && !rready && !rst;
        prev_out = {rid, rdata, rresp, rlast};
        @(posedge clk);
        @(negedge clk);
        armed = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        rready = 1'b0;
        fifo_rempty = 1'b1;
        fifo_rdata = '0;
        for (int i = 0; i < 4; i++) load(8'(i), 32'(8'h11 * (i + 1)), RESP_OKAY, i == 3);
        @(negedge clk);
        repeat (3) step(1'b1);
        rst = 1'b0;
        repeat (8) step(1'b1);
        chk("bd_count", bd_count, 1);
        for (int i = 0; i < 5; i++) load(8'(8'h20 + i), 32'(32'h100 + i), RESP_OKAY, i == 4);
        repeat (6) step(1'b0);
        repeat (8) step(1'b1);
        for (int i = 0; i < 48; i++) begin
            if (i % 3 == 0) load(8'($urandom), $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
            step(i % 2 == 0);
        end
        load(8'h7f, 32'h7f, RESP_OKAY, 1'b1);
        repeat (10) step(1'b1);
        load(8'hA5, 32'hDEADBEEF, RESP_SLVERR, 1'b1);
        repeat (4) step(1'b1);
        for (int i = 0; i < 257; i++) load(8'(i), 32'(i), RESP_OKAY, 1'b0);
        repeat (262) step(1'b1);
        chk("overrun_set", overrun_err, 1);
        repeat (3) step(1'b1);
        for (int i = 0; i < 4; i++) load(8'(8'h30 + i), 32'(32'h300 + i), RESP_EXOKAY, i == 3);
        repeat (4) step(1'b0);
        rst = 1'b1;
        repeat (2) step(1'b0);
        rst = 1'b0;
        repeat (10) step(1'b1);
        chk("overrun_clr", overrun_err, 0);
        chk("drained", exp_q.size(), 0);
        chk("fifo_empty", fq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
